// File: rtl/spi_minion_frontend.sv
// SPI minion front-end: synchronizes SPI pins into clk, shifts NBITS+2 bit frames,
// and bridges them to val/rdy streams through small rx/tx FIFOs.
module spi_minion_frontend #(
    parameter int NBITS       = 32,
    parameter int NUM_ENTRIES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs,
    input  logic             sclk,
    input  logic             mosi,
    output logic             miso,
    output logic [NBITS-1:0] out_msg,
    output logic             out_val,
    input  logic             out_rdy,
    input  logic [NBITS-1:0] in_msg,
    input  logic             in_val,
    output logic             in_rdy,
    output logic             parity
);

    localparam int FW = NBITS + 2;
    localparam int AW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam int CW = $clog2(NBITS + 4);
    localparam logic [AW:0]   DEPTH_C     = (AW+1)'(NUM_ENTRIES);
    localparam logic [AW-1:0] PTR_ONE_C   = AW'(1);
    localparam logic [AW:0]   CNT_ONE_C   = (AW+1)'(1);
    localparam logic [CW-1:0] BIT_FRAME_C = CW'(FW);
    localparam logic [CW-1:0] BIT_MAX_C   = CW'(FW + 1);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    logic cs_meta_r, cs_sync_r, cs_prev_r, cs_armed_r;
    logic sclk_meta_r, sclk_sync_r, sclk_prev_r;
    logic mosi_meta_r, mosi_sync_r;

    state_t          state_r;
    logic [FW-1:0]   out_sr_r;
    logic [FW-1:0]   in_sr_r;
    logic [CW-1:0]   bit_cnt_r;
    logic            rx_space_r;
    logic            tx_avail_r;

    logic [NBITS-1:0] rx_mem_r [NUM_ENTRIES];
    logic [AW-1:0]    rx_wp_r, rx_rp_r;
    logic [AW:0]      rx_cnt_r;
    logic [NBITS-1:0] tx_mem_r [NUM_ENTRIES];
    logic [AW-1:0]    tx_wp_r, tx_rp_r;
    logic [AW:0]      tx_cnt_r;

    logic cs_fall_s, cs_rise_s, sclk_rise_s, sclk_fall_s;
    logic frame_end_s, rx_push_s, rx_pop_s, tx_push_s, tx_pop_s;
    logic rx_full_s, tx_full_s, tx_empty_s;
    logic [NBITS-1:0] tx_head_s;

    // Two-flop synchronizers plus one edge-detect stage; cs_armed_r blocks a fall
    // that is only the artefact of cs being low while reset was released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_meta_r   <= 1'b1;
            cs_sync_r   <= 1'b1;
            cs_prev_r   <= 1'b1;
            cs_armed_r  <= 1'b0;
            sclk_meta_r <= 1'b0;
            sclk_sync_r <= 1'b0;
            sclk_prev_r <= 1'b0;
            mosi_meta_r <= 1'b0;
            mosi_sync_r <= 1'b0;
        end else begin
            cs_meta_r   <= cs;
            cs_sync_r   <= cs_meta_r;
            cs_prev_r   <= cs_sync_r;
            cs_armed_r  <= cs_armed_r | cs_sync_r;
            sclk_meta_r <= sclk;
            sclk_sync_r <= sclk_meta_r;
            sclk_prev_r <= sclk_sync_r;
            mosi_meta_r <= mosi;
            mosi_sync_r <= mosi_meta_r;
        end
    end

    // Edge strobes, FIFO status and the frame-end push/pop decisions.
    always_comb begin
        cs_fall_s   = cs_prev_r & ~cs_sync_r & cs_armed_r;
        cs_rise_s   = ~cs_prev_r & cs_sync_r;
        sclk_rise_s = ~sclk_prev_r & sclk_sync_r;
        sclk_fall_s = sclk_prev_r & ~sclk_sync_r;
        rx_full_s   = (rx_cnt_r == DEPTH_C);
        tx_full_s   = (tx_cnt_r == DEPTH_C);
        tx_empty_s  = (tx_cnt_r == '0);
        tx_head_s   = tx_mem_r[tx_rp_r];
        if (state_r == ACTIVE) begin
            frame_end_s = cs_rise_s & (bit_cnt_r == BIT_FRAME_C);
        end else begin
            frame_end_s = 1'b0;
        end
        rx_push_s = frame_end_s & in_sr_r[FW-1] & rx_space_r;
        tx_pop_s  = frame_end_s & in_sr_r[FW-2] & tx_avail_r;
        rx_pop_s  = out_val & out_rdy;
        tx_push_s = in_val & ~tx_full_s;
    end

    // Frame FSM: snapshot on cs fall, shift on sclk edges, return to IDLE on cs rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            out_sr_r   <= '0;
            in_sr_r    <= '0;
            bit_cnt_r  <= '0;
            rx_space_r <= 1'b0;
            tx_avail_r <= 1'b0;
            miso       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cs_fall_s) begin
                        state_r    <= ACTIVE;
                        out_sr_r   <= {~rx_full_s, ~tx_empty_s,
                                       tx_empty_s ? {NBITS{1'b0}} : tx_head_s};
                        rx_space_r <= ~rx_full_s;
                        tx_avail_r <= ~tx_empty_s;
                        bit_cnt_r  <= '0;
                        miso       <= ~rx_full_s;
                    end
                end
                ACTIVE: begin
                    if (cs_rise_s) begin
                        state_r <= IDLE;
                        miso    <= 1'b0;
                    end else begin
                        if (sclk_rise_s) begin
                            in_sr_r <= {in_sr_r[FW-2:0], mosi_sync_r};
                            if (bit_cnt_r != BIT_MAX_C) begin
                                bit_cnt_r <= bit_cnt_r + CW'(1);
                            end
                        end
                        if (sclk_fall_s) begin
                            out_sr_r <= {out_sr_r[FW-2:0], 1'b0};
                            miso     <= out_sr_r[FW-2];
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    miso    <= 1'b0;
                end
            endcase
        end
    end

    // rx FIFO: written at a good frame end, drained by the interconnect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_wp_r  <= '0;
            rx_rp_r  <= '0;
            rx_cnt_r <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) rx_mem_r[i] <= '0;
        end else begin
            if (rx_push_s) begin
                rx_mem_r[rx_wp_r] <= in_sr_r[NBITS-1:0];
                rx_wp_r           <= rx_wp_r + PTR_ONE_C;
            end
            if (rx_pop_s) begin
                rx_rp_r <= rx_rp_r + PTR_ONE_C;
            end
            case ({rx_push_s, rx_pop_s})
                2'b10:   rx_cnt_r <= rx_cnt_r + CNT_ONE_C;
                2'b01:   rx_cnt_r <= rx_cnt_r - CNT_ONE_C;
                default: rx_cnt_r <= rx_cnt_r;
            endcase
        end
    end

    // tx FIFO: filled by the interconnect, consumed by a read frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wp_r  <= '0;
            tx_rp_r  <= '0;
            tx_cnt_r <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) tx_mem_r[i] <= '0;
        end else begin
            if (tx_push_s) begin
                tx_mem_r[tx_wp_r] <= in_msg;
                tx_wp_r           <= tx_wp_r + PTR_ONE_C;
            end
            if (tx_pop_s) begin
                tx_rp_r <= tx_rp_r + PTR_ONE_C;
            end
            case ({tx_push_s, tx_pop_s})
                2'b10:   tx_cnt_r <= tx_cnt_r + CNT_ONE_C;
                2'b01:   tx_cnt_r <= tx_cnt_r - CNT_ONE_C;
                default: tx_cnt_r <= tx_cnt_r;
            endcase
        end
    end

    assign out_msg = rx_mem_r[rx_rp_r];
    assign out_val = (rx_cnt_r != '0);
    assign in_rdy  = ~tx_full_s;
    assign parity  = out_val & (^out_msg);

endmodule

// File: tb/tb_spi_minion_frontend.sv
// Bench for spi_minion_frontend (NBITS=8): directed plan steps plus random traffic,
// checked against a queue-based model of the two FIFOs and the frame rules.
module tb_spi_minion_frontend;

    localparam int NB    = 8;
    localparam int DEPTH = 2;
    localparam int HALF  = 80;

    logic          clk = 1'b0;
    logic          reset, cs, sclk, mosi, miso;
    logic [NB-1:0] out_msg, in_msg;
    logic          out_val, out_rdy, in_val, in_rdy, parity;

    int checks   = 0;
    int failures = 0;

    logic [NB-1:0] rx_q[$];
    logic [NB-1:0] tx_q[$];

    spi_minion_frontend #(.NBITS(NB), .NUM_ENTRIES(DEPTH)) dut (
        .clk(clk), .reset(reset), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso),
        .out_msg(out_msg), .out_val(out_val), .out_rdy(out_rdy),
        .in_msg(in_msg), .in_val(in_val), .in_rdy(in_rdy), .parity(parity)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_out_val"}, {31'd0, out_val}, {31'd0, rx_q.size() > 0});
        if (rx_q.size() > 0) begin
            chk({tag, "_out_msg"}, {24'd0, out_msg}, {24'd0, rx_q[0]});
            chk({tag, "_parity"}, {31'd0, parity}, {31'd0, ^rx_q[0]});
        end else begin
            chk({tag, "_parity"}, {31'd0, parity}, 32'd0);
        end
        chk({tag, "_in_rdy"}, {31'd0, in_rdy}, {31'd0, tx_q.size() < DEPTH});
    endtask

    // Mode 0 master: mosi set before each rising edge, miso sampled on the rising edge.
    task automatic spi_xfer(input logic [15:0] bits, input int n, input int rst_at,
                            output logic [15:0] got);
        int idx;
        got  = 16'd0;
        cs   = 1'b0;
        mosi = bits[n-1];
        #HALF;
        for (int i = 0; i < n; i++) begin
            sclk = 1'b1;
            got  = {got[14:0], miso};
            if (i == rst_at) begin
                reset = 1'b1;
                #20;
                reset = 1'b0;
                #(HALF - 20);
            end else begin
                #HALF;
            end
            sclk = 1'b0;
            idx  = n - 2 - i;
            mosi = (idx >= 0) ? bits[idx] : 1'b0;
            #HALF;
        end
        cs = 1'b1;
        #HALF;
    endtask

    task automatic frame(input string tag, input logic wr, input logic rd,
                         input logic [NB-1:0] d, output logic [9:0] got10);
        logic [15:0] got;
        logic        rs, ta;
        logic [9:0]  exp;
        rs  = rx_q.size() < DEPTH;
        ta  = tx_q.size() > 0;
        exp = {rs, ta, ta ? tx_q[0] : 8'h00};
        spi_xfer({6'd0, wr, rd, d}, 10, -1, got);
        got10 = got[9:0];
        chk({tag, "_miso"}, {22'd0, got10}, {22'd0, exp});
        if (wr && rs) rx_q.push_back(d);
        if (rd && ta) void'(tx_q.pop_front());
        check_outputs(tag);
    endtask

    task automatic bad_frame(input string tag, input int n, input logic [15:0] bits);
        logic [15:0] got;
        spi_xfer(bits, n, -1, got);
        check_outputs(tag);
    endtask

    task automatic pop_rx(input string tag);
        out_rdy = 1'b1;
        #10;
        out_rdy = 1'b0;
        if (rx_q.size() > 0) void'(rx_q.pop_front());
        #10;
        check_outputs(tag);
    endtask

    task automatic push_tx(input string tag, input logic [NB-1:0] v);
        in_msg = v;
        in_val = 1'b1;
        #10;
        in_val = 1'b0;
        if (tx_q.size() < DEPTH) tx_q.push_back(v);
        #10;
        check_outputs(tag);
    endtask

    initial begin
        logic [9:0]  g;
        int          r, n;
        logic [15:0] bits;
        logic [15:0] got;

        reset = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
        out_rdy = 1'b0; in_msg = '0; in_val = 1'b0;
        #42;
        chk("rst_miso", {31'd0, miso}, 32'd0);
        chk("rst_out_val", {31'd0, out_val}, 32'd0);
        chk("rst_parity", {31'd0, parity}, 32'd0);
        chk("rst_in_rdy", {31'd0, in_rdy}, 32'd1);
        reset = 1'b0;
        #20;

        // Plan 1: write A5, hold, then accept
        frame("t1", 1'b1, 1'b0, 8'hA5, g);
        chk("t1_msg_a5", {24'd0, out_msg}, 32'h0000_00A5);
        chk("t1_par0", {31'd0, parity}, 32'd0);
        pop_rx("t1_pop");
        chk("t1_val0", {31'd0, out_val}, 32'd0);

        // Plan 2: odd parity payload
        frame("t2", 1'b1, 1'b0, 8'h07, g);
        chk("t2_par1", {31'd0, parity}, 32'd1);
        pop_rx("t2_pop");

        // Plan 3: read back one response, then read from empty tx FIFO
        push_tx("t3_push", 8'h3C);
        frame("t3a", 1'b0, 1'b1, 8'h00, g);
        chk("t3a_seq", {22'd0, g}, {22'd0, 10'b11_0011_1100});
        chk("t3a_in_rdy", {31'd0, in_rdy}, 32'd1);
        frame("t3b", 1'b0, 1'b1, 8'h00, g);
        chk("t3b_seq", {22'd0, g}, {22'd0, 10'b10_0000_0000});

        // Plan 4: fill rx FIFO, third write dropped, drain in order
        frame("t4a", 1'b1, 1'b0, 8'h11, g);
        frame("t4b", 1'b1, 1'b0, 8'h22, g);
        frame("t4c", 1'b1, 1'b0, 8'h33, g);
        chk("t4c_first", {31'd0, g[9]}, 32'd0);
        chk("t4_head11", {24'd0, out_msg}, 32'h0000_0011);
        pop_rx("t4_pop1");
        chk("t4_head22", {24'd0, out_msg}, 32'h0000_0022);
        pop_rx("t4_pop2");

        // Plan 5: wrong frame lengths are discarded
        bad_frame("t5_short", 7, 16'b0000_0000_0110_0101);
        bad_frame("t5_long", 11, 16'b0000_0101_0110_0101);
        frame("t5_ok", 1'b1, 1'b0, 8'hC3, g);
        pop_rx("t5_pop");

        // Plan 6: reset after 5 sclk edges, finish the frame, then a clean frame
        push_tx("t6_push", 8'h99);
        spi_xfer({6'd0, 2'b10, 8'h77}, 10, 2, got);
        rx_q.delete();
        tx_q.delete();
        chk("t6_miso0", {31'd0, miso}, 32'd0);
        check_outputs("t6_after_rst");
        frame("t6_ok", 1'b1, 1'b0, 8'h5A, g);
        chk("t6_msg_5a", {24'd0, out_msg}, 32'h0000_005A);
        pop_rx("t6_pop");

        // Random traffic against the model
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 5);
            case (r)
                0: push_tx("rnd_push", 8'($urandom));
                1: pop_rx("rnd_pop");
                2: begin
                    n = ($urandom_range(0, 1) == 0) ? $urandom_range(3, 9)
                                                    : $urandom_range(11, 14);
                    bits = 16'($urandom);
                    bad_frame("rnd_bad", n, bits);
                end
                default: frame("rnd_frame", 1'($urandom), 1'($urandom), 8'($urandom), g);
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
